// File: rtl/conversor_bcd_display_pkg.sv
// Shared definitions for the BCD converter and its multiplexed 7-segment display:
// FSM encodings, segment constants, digit count and the double-dabble adjust step.
package conversor_bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          NUM_DIGITS = 5;
  localparam int          BIN_W      = 14;
  localparam int          BCD_W      = 16;
  localparam logic [3:0]  ITER_LAST  = 4'd13;

  localparam logic [6:0]  SEG_BLANK  = 7'b1111111;
  localparam logic [6:0]  SEG_MINUS  = 7'b0111111;
  localparam logic [6:0]  SEG_ZERO   = 7'b1000000;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [15:0] dd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational BCD digit to active-low segment pattern {g,f,e,d,c,b,a};
// codes above 9 come out blank.
module decodificador_7seg
  import conversor_bcd_display_pkg::*;
(
  input  logic [3:0] digito,
  output logic [6:0] seg
);

  // Standard digit patterns.
  always_comb begin
    seg = SEG_BLANK;
    case (digito)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/conversor_bcd_display.sv
// Signed 14-bit to 4-digit BCD converter (sequential double dabble) driving a
// 5-digit multiplexed display: sign digit plus four magnitude digits.
module conversor_bcd_display #(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] valor,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        negativo,
  output logic [6:0]  seg,
  output logic [4:0]  an
);
  import conversor_bcd_display_pkg::*;

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  state_t           state_r, state_next_s;
  logic [BIN_W-1:0] bin_r, bin_next_s;
  logic [BCD_W-1:0] work_r, work_next_s, adj_s;
  logic [29:0]      shifted_s;
  logic [3:0]       iter_r, iter_next_s;
  logic             sign_r, sign_next_s;
  logic [BCD_W-1:0] bcd_r, bcd_next_s;
  logic             negativo_r, negativo_next_s;
  logic             busy_r, done_r;

  logic [DIV_W-1:0] div_r, div_next_s;
  logic [2:0]       digit_r, digit_next_s;
  logic [3:0]       nibble_s;
  logic             blank_s, sign_slot_s;
  logic [6:0]       dec_s, seg_next_s;
  logic [4:0]       an_r, an_next_s;
  logic [6:0]       seg_r;

  assign adj_s     = dd_adjust(work_r);
  assign shifted_s = {adj_s, bin_r} << 1;

  // Conversion FSM next-state and datapath.
  always_comb begin
    state_next_s    = state_r;
    bin_next_s      = bin_r;
    work_next_s     = work_r;
    iter_next_s     = iter_r;
    sign_next_s     = sign_r;
    bcd_next_s      = bcd_r;
    negativo_next_s = negativo_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          sign_next_s  = valor[13];
          bin_next_s   = valor[13] ? (~valor + 14'd1) : valor;
          work_next_s  = 16'd0;
          iter_next_s  = 4'd0;
          state_next_s = SHIFT;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        work_next_s = shifted_s[29:14];
        bin_next_s  = shifted_s[13:0];
        iter_next_s = iter_r + 4'd1;
        if (iter_r == ITER_LAST) begin
          // Result is published on the same edge that enters DONE.
          bcd_next_s      = shifted_s[29:14];
          negativo_next_s = sign_r;
          state_next_s    = DONE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Conversion state and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      bin_r      <= 14'd0;
      work_r     <= 16'd0;
      iter_r     <= 4'd0;
      sign_r     <= 1'b0;
      bcd_r      <= 16'd0;
      negativo_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      bin_r      <= bin_next_s;
      work_r     <= work_next_s;
      iter_r     <= iter_next_s;
      sign_r     <= sign_next_s;
      bcd_r      <= bcd_next_s;
      negativo_r <= negativo_next_s;
      busy_r     <= (state_next_s == SHIFT);
      done_r     <= (state_next_s == DONE);
    end
  end

  // Scan divider, digit selection and leading-zero blanking.
  always_comb begin
    div_next_s   = div_r;
    digit_next_s = digit_r;
    if (div_r == DIV_W'(CLK_DIV - 1)) begin
      div_next_s   = '0;
      digit_next_s = (digit_r == 3'(NUM_DIGITS - 1)) ? 3'd0 : digit_r + 3'd1;
    end else begin
      div_next_s = div_r + 1'b1;
    end
    nibble_s    = 4'd0;
    blank_s     = 1'b0;
    sign_slot_s = 1'b0;
    case (digit_next_s)
      3'd0: nibble_s = bcd_next_s[3:0];
      3'd1: begin
        nibble_s = bcd_next_s[7:4];
        blank_s  = (bcd_next_s[15:4] == 12'd0);
      end
      3'd2: begin
        nibble_s = bcd_next_s[11:8];
        blank_s  = (bcd_next_s[15:8] == 8'd0);
      end
      3'd3: begin
        nibble_s = bcd_next_s[15:12];
        blank_s  = (bcd_next_s[15:12] == 4'd0);
      end
      3'd4:    sign_slot_s = 1'b1;
      default: blank_s = 1'b1;
    endcase
    if (sign_slot_s) begin
      seg_next_s = negativo_next_s ? SEG_MINUS : SEG_BLANK;
    end else if (blank_s) begin
      seg_next_s = SEG_BLANK;
    end else begin
      seg_next_s = dec_s;
    end
    an_next_s = ~(5'b00001 << digit_next_s);
  end

  decodificador_7seg u_dec (
    .digito (nibble_s),
    .seg    (dec_s)
  );

  // Display scan registers; seg and an always describe the same digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r   <= '0;
      digit_r <= 3'd0;
      an_r    <= 5'b11110;
      seg_r   <= SEG_ZERO;
    end else begin
      div_r   <= div_next_s;
      digit_r <= digit_next_s;
      an_r    <= an_next_s;
      seg_r   <= seg_next_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign bcd      = bcd_r;
  assign negativo = negativo_r;
  assign seg      = seg_r;
  assign an       = an_r;

endmodule

// File: tb/tb_conversor_bcd_display.sv
// Directed self-checking bench for conversor_bcd_display with a short scan period.
module tb_conversor_bcd_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] valor;
  logic        start;
  logic        busy, done, negativo;
  logic [15:0] bcd;
  logic [6:0]  seg;
  logic [4:0]  an;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  conversor_bcd_display #(.CLK_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valor    (valor),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .negativo (negativo),
    .seg      (seg),
    .an       (an)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request a conversion and return cycles from the sampling edge until done.
  task automatic convert(input logic [13:0] v, input logic [15:0] prev_bcd, output int lat);
    @(negedge clk);
    valor = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    check("hold_bcd", {16'd0, bcd}, {16'd0, prev_bcd});
    check("busy_run", {31'd0, busy}, 32'd1);
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  logic [4:0] exp_an  [5];
  logic [6:0] exp_seg [5];

  initial begin
    int lat;
    int dones;
    int guard;

    exp_an[0] = 5'b11110; exp_seg[0] = 7'b0100100;
    exp_an[1] = 5'b11101; exp_seg[1] = 7'b0011001;
    exp_an[2] = 5'b11011; exp_seg[2] = 7'b1111111;
    exp_an[3] = 5'b10111; exp_seg[3] = 7'b1111111;
    exp_an[4] = 5'b01111; exp_seg[4] = 7'b0111111;

    rst_n = 1'b0;
    start = 1'b0;
    valor = 14'd0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bcd", {16'd0, bcd}, 32'd0);
    check("rst_neg", {31'd0, negativo}, 32'd0);
    check("rst_an", {27'd0, an}, 32'h1E);
    check("rst_seg", {25'd0, seg}, 32'h40);
    @(negedge clk);
    rst_n = 1'b1;

    convert(14'h3FF6, 16'h0000, lat);
    check("lat_m10", lat, 32'd15);
    check("bcd_m10", {16'd0, bcd}, 32'h0010);
    check("neg_m10", {31'd0, negativo}, 32'd1);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);

    convert(14'h1000, 16'h0010, lat);
    check("lat_4096", lat, 32'd15);
    check("bcd_4096", {16'd0, bcd}, 32'h4096);
    check("neg_4096", {31'd0, negativo}, 32'd0);

    convert(14'h2000, 16'h4096, lat);
    check("bcd_m8192", {16'd0, bcd}, 32'h8192);
    check("neg_m8192", {31'd0, negativo}, 32'd1);

    convert(14'h1FFF, 16'h8192, lat);
    check("bcd_8191", {16'd0, bcd}, 32'h8191);
    check("neg_8191", {31'd0, negativo}, 32'd0);

    // Second start while busy must be dropped.
    @(negedge clk);
    valor = 14'h0005;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    valor = 14'h0007;
    start = 1'b1;
    check("busy_ign", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("single_done", dones, 32'd1);
    check("bcd_5", {16'd0, bcd}, 32'h0005);

    convert(14'h3FD6, 16'h0005, lat);
    check("bcd_m42", {16'd0, bcd}, 32'h0042);
    check("neg_m42", {31'd0, negativo}, 32'd1);

    guard = 0;
    while (an !== 5'b01111 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    guard = 0;
    while (an !== 5'b11110 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("an_slot%0d", k), {27'd0, an}, {27'd0, exp_an[k]});
      check($sformatf("seg_slot%0d", k), {25'd0, seg}, {25'd0, exp_seg[k]});
      repeat (4) @(negedge clk);
    end
    check("an_wrap", {27'd0, an}, 32'h1E);

    // Reset in the 7th SHIFT cycle.
    @(negedge clk);
    valor = 14'd1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_pre_rst", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    check("rst_async_bcd", {16'd0, bcd}, 32'd0);
    check("rst_async_an", {27'd0, an}, 32'h1E);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("no_done_rst", dones, 32'd0);

    convert(14'h0000, 16'h0000, lat);
    check("lat_0", lat, 32'd15);
    check("bcd_0", {16'd0, bcd}, 32'd0);
    check("neg_0", {31'd0, negativo}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conversor_bcd_display.md
CONVERSOR_BCD_DISPLAY -- requirements
Module: conversor_bcd_display

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, meaning clk cycles per display digit slot (minimum 2).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port valor  input  14  ALU result, two's complement.
REQ-005 SHALL have port start  input  1  conversion request, sampled only in IDLE.
REQ-006 SHALL have port busy  output  1  high while a conversion runs.
REQ-007 SHALL have port done  output  1  one-cycle pulse when the new result is valid.
REQ-008 SHALL have port bcd  output  16  held magnitude, 4 BCD digits, digit 3 in [15:12].
REQ-009 SHALL have port negativo  output  1  held sign of the last converted value.
REQ-010 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port an  output  5  active-low digit enables; an[4] = sign digit, an[0] = units.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE; reset state is IDLE.
REQ-013 In IDLE with start=1 at an edge, SHALL latch sign=valor[13] and magnitude=|valor| (invert and add 1 when negative), then enter SHIFT.
REQ-014 SHALL perform one shift-add-3 (double dabble) iteration per cycle in SHIFT: add 3 to every BCD nibble >=5, then shift left one bit; exactly 14 iterations.
REQ-015 After the 14th iteration SHALL enter DONE for exactly one cycle, then return to IDLE.
REQ-016 SHALL update bcd and negativo on the edge entering DONE; done=1 only in DONE; busy=1 only in SHIFT.
REQ-017 Latency: done SHALL be high in the 15th cycle after the edge that sampled start.
REQ-018 start while busy or done SHALL be ignored; no queuing.
REQ-019 valor=14'h2000 (-8192) SHALL convert to magnitude 8192, negativo=1; magnitude never exceeds 8192, so 4 digits suffice.
REQ-020 bcd and negativo SHALL keep the previous result during a conversion; the display never shows partial values.
REQ-021 Scan: the divider counts 0..CLK_DIV-1; on wrap the digit index advances 0,1,2,3,4,0; exactly one an bit is low at any time.
REQ-022 Digits 3..1 SHALL be blanked (seg=7'b1111111) when they and all higher digits are zero; the units digit is always shown.
REQ-023 The sign digit SHALL show '-' (7'b0111111) when negativo=1, otherwise blank.
REQ-024 BCD 0-9 SHALL map to standard patterns, '0' = 7'b1000000; codes above 9 show blank.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, bcd=0, negativo=0, divider=0, digit index=0, an=5'b11110, seg=7'b1000000.
REQ-026 Reset during SHIFT SHALL abort the conversion with no done pulse; the next start after release behaves normally.

Structure
REQ-027 A shared package/include SHALL hold the FSM state encodings, the segment constants (blank, minus) and the digit count 5.
REQ-028 The BCD-to-segment decode SHALL be a combinational sub-module decodificador_7seg (4-bit in, 7-bit active-low out).

Verification
REQ-029 valor=14'h3FF6 (-10), start pulse -> done 15 cycles later, bcd=16'h0010, negativo=1.
REQ-030 valor=14'h1000 (4096) -> bcd=16'h4096, negativo=0; valor=14'h2000 -> bcd=16'h8192, negativo=1.
REQ-031 start with 14'h0005, then start with 14'h0007 while busy -> single done, bcd=16'h0005.
REQ-032 rst_n low on the 7th SHIFT cycle -> busy=0 and bcd=0 without waiting for an edge, no done; after release, start with 0 -> bcd=0, negativo=0.
REQ-033 CLK_DIV=4, held bcd=16'h0042, negativo=1 -> an steps 11110,11101,11011,10111,01111 every 4 cycles; seg shows '2','4', blank, blank, '-'.
